// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the round-robin ALU sequencer.
// Latency: none (types and constants only).
// Backpressure: n/a.
// Contents: alu_op_e op codes, seq_state_e FSM states, datapath widths and
// an op-legality helper used when ALU_OP_CHECK_EN is defined.
package alu_seq_pkg;

  localparam int ALU_OP_W   = 3;
  localparam int ALU_DATA_W = 16;
  localparam int ALU_RES_W  = 17;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  // Codes above XOR have no ALU meaning.
  function automatic logic op_is_legal(input logic [ALU_OP_W-1:0] op);
    return (op <= ALU_OP_W'(XOR));
  endfunction

endpackage

// File: rtl/alu_rr_sequencer_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: req[N-1:0] requests, ptr highest-priority index,
//        gnt one-hot grant, gnt_idx grant index, any = some request present.
module rr_arbiter
  import alu_seq_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  int idx;

  // Scan from the lowest-priority slot (ptr+N-1) up to ptr itself, so the
  // last hit written is the requester closest to ptr.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one combinational 16-bit ALU among N requesters with round-robin grants.
// Latency: accept cycle T -> resp_valid from T+2; one operation per 3 cycles at best.
// Backpressure: holds the response in RESP until resp_ready; no grants outside IDLE.
// Ports: clk/rst (async active-high); req_valid/req_ready/req_in1/req_in2/req_op
//        per-requester slices; alu_in1/alu_in2/alu_op registered ALU drive,
//        alu_out ALU result; resp_valid/resp_ready/resp_id/resp_data/resp_err.
// Optional macro ALU_OP_CHECK_EN: ops >4 are not issued to the ALU and return
// resp_data=0 with resp_err=1; without it every op is forwarded and resp_err=0.
module alu_rr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req_valid,
  output logic [N-1:0]            req_ready,
  input  logic [ALU_DATA_W*N-1:0] req_in1,
  input  logic [ALU_DATA_W*N-1:0] req_in2,
  input  logic [ALU_OP_W*N-1:0]   req_op,
  output logic [ALU_DATA_W-1:0]   alu_in1,
  output logic [ALU_DATA_W-1:0]   alu_in2,
  output logic [ALU_OP_W-1:0]     alu_op,
  input  logic [ALU_RES_W-1:0]    alu_out,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [ALU_RES_W-1:0]    resp_data,
  output logic                    resp_err
);

  seq_state_e            state;
  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       ptr_nxt;
  logic [N-1:0]          gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  gnt_any;
  logic [ALU_DATA_W-1:0] win_in1;
  logic [ALU_DATA_W-1:0] win_in2;
  logic [ALU_OP_W-1:0]   win_op;

  rr_arbiter #(.N(N), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Grant is only offered in IDLE and never while reset is held.
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;

  assign win_in1 = req_in1[int'(gnt_idx)*ALU_DATA_W +: ALU_DATA_W];
  assign win_in2 = req_in2[int'(gnt_idx)*ALU_DATA_W +: ALU_DATA_W];
  assign win_op  = req_op[int'(gnt_idx)*ALU_OP_W +: ALU_OP_W];

  // Explicit wrap so non-power-of-two N returns to 0 after N-1.
  assign ptr_nxt = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;

`ifdef ALU_OP_CHECK_EN
  logic bad_op;
  logic err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= '0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
`ifdef ALU_OP_CHECK_EN
      bad_op     <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            resp_id <= gnt_idx;
            ptr     <= ptr_nxt;
            state   <= EXEC;
`ifdef ALU_OP_CHECK_EN
            // Illegal ops still burn the EXEC cycle but leave the ALU drive untouched.
            bad_op <= !op_is_legal(win_op);
            if (op_is_legal(win_op)) begin
              alu_in1 <= win_in1;
              alu_in2 <= win_in2;
              alu_op  <= win_op;
            end
`else
            alu_in1 <= win_in1;
            alu_in2 <= win_in2;
            alu_op  <= win_op;
`endif
          end
        end
        EXEC: begin
`ifdef ALU_OP_CHECK_EN
          resp_data <= bad_op ? '0 : alu_out;
          err_q     <= bad_op;
`else
          resp_data <= alu_out;
`endif
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
- Shares one 16-bit ALU between N requesters using round-robin arbitration and valid/ready handshakes.
- ALU op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; codes 5-7 produce 0. The ALU returns a 17-bit result.
- The block captures the winner's operands, drives the ALU from registers for one cycle, then holds a registered response until it is consumed.
- Sits between requesting engines and the combinational ALU.

Parameters:
- N, default 4: number of requesters; legal range 1..16.
- ID_W, default $clog2(N) with a floor of 1: width of the requester index.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester accept, at most one bit high.
- req_in1  in  16*N  operand A; slice i belongs to requester i.
- req_in2  in  16*N  operand B; slice i belongs to requester i.
- req_op  in  3*N  op code; slice i belongs to requester i.
- alu_in1  out  16  to ALU in1 (registered).
- alu_in2  out  16  to ALU in2 (registered).
- alu_op  out  3  to ALU operation (registered).
- alu_out  in  17  ALU result (combinational return).
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_data  out  17  result.
- resp_err  out  1  illegal op flag; see Optional Feature.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr pointer=0. All operand/op/result/id regs=0. req_ready=0, resp_valid=0, resp_err=0, alu_*=0.
- FSM states IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - grant g = first index with req_valid set, searching ptr, ptr+1, ..., wrapping mod N.
  - req_ready[g]=1 combinationally and only in IDLE; all other bits 0.
  - On the handshake edge: latch in1/in2/op slice g and id=g, set ptr=(g+1) mod N, go to EXEC.
  - With no req_valid: stay in IDLE, ptr unchanged.
- EXEC (exactly 1 cycle):
  - alu_* hold the latched values.
  - At the end of the cycle: latch alu_out into resp_data, go to RESP.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err stay stable.
  - Leave to IDLE only on resp_valid&&resp_ready.
  - While resp_ready=0: stay in RESP, no new grants.
- alu_in1, alu_in2 and alu_op change only on an IDLE handshake; they hold their values in every other state.
- Latency: accept edge T gives resp_valid high from T+2. Peak throughput is 1 operation per 3 cycles.
- Requester rules: hold req_valid and payload stable until req_ready. Deasserting before grant is legal; the request is simply not taken.
- Simultaneous events: a response handshake and pending requests in the same cycle means grant happens in the following IDLE cycle (no bypass). A request arriving during EXEC/RESP waits.
- Arithmetic: no width handling in this block; the 17-bit alu_out passes through unmodified.
- SUB wrap: 0-1 gives 17'h1FFFF.
- N=1: the pointer stays 0; resp_id is 0.
- rst mid-transaction: the transaction is dropped, no response is produced, and the block returns to reset values.

Optional Feature:
- Macro ALU_OP_CHECK_EN.
- Defined:
  - An op code >4 is still accepted and still spends one cycle in EXEC.
  - resp_data is forced to 0 and resp_err=1 in RESP.
  - The ALU is not issued the new op: alu_* hold their previous values.
- Undefined:
  - All op codes are forwarded to the ALU and resp_data=alu_out.
  - resp_err is tied to 0.

Decomposition:
- Package alu_seq_pkg:
  - typedef alu_op_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4.
  - constants ALU_OP_W=3, ALU_DATA_W=16, ALU_RES_W=17.
  - typedef seq_state_e: IDLE, EXEC, RESP.
- Sub-module rr_arbiter:
  - parameter N.
  - inputs req[N-1:0], ptr.
  - outputs one-hot gnt, gnt_idx, any.
  - Purely combinational.

Test Plan:
- Reset then a single request: requester 2 with in1=16'h0005, in2=16'h0003, op=0, N=4. Required: req_ready[2] in the same cycle; resp_valid 2 cycles later with resp_data=17'h00008, resp_id=2.
- SUB underflow: in1=0, in2=1, op=1. Required: resp_data=17'h1FFFF, resp_err=0.
- Fairness: all 4 requesters hold valid continuously, resp_ready=1. Required: grant order 0,1,2,3,0. The pointer after each grant is g+1.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid. Required: resp_data/resp_id stable, req_ready all 0, and the next grant comes in the cycle after resp_ready=1 completes the handshake.
- Illegal op 6 with in1=16'hFFFF. Required with ALU_OP_CHECK_EN: resp_data=0, resp_err=1, alu_op unchanged. Required without it: resp_data=0, resp_err=0, alu_op=6.
- Reset asserted during EXEC. Required: resp_valid never rises, and the next request is served starting from ptr=0.
